// File: rtl/pipe_seq_ctrl.sv
// Pipeline sequencing controller: merges load-use, branch, multi-cycle EXE and
// data-memory-wait causes into per-stage hold/flush controls plus a stall counter.
module pipe_seq_ctrl #(
    parameter int MC_CYCLES = 4,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_hazard,
    input  logic             br_taken,
    input  logic             mc_start,
    input  logic             mem_ready,
    input  logic             cnt_clr,
    output logic             stall_fe,
    output logic             stall_de,
    output logic             stall_ex,
    output logic             stall_me,
    output logic             flush_de,
    output logic             flush_ex,
    output logic             bubble_me,
    output logic             mc_done,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {RUN, LDSTALL, MCWAIT} state_e;

    state_e           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= RUN;
            cnt_q          <= '0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stall_fe  = 1'b1;
        stall_de  = 1'b1;
        stall_ex  = 1'b1;
        stall_me  = 1'b1;
        flush_de  = 1'b0;
        flush_ex  = 1'b0;
        bubble_me = 1'b0;
        mc_done   = 1'b0;
        // Outputs are Mealy, so they are gated by reset to stay quiet while held.
        if (!rst) begin
            state_d = RUN;
        end else if (!mem_ready) begin
            stall_fe = 1'b0;
            stall_de = 1'b0;
            stall_ex = 1'b0;
            stall_me = 1'b0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (br_taken) begin
                        flush_de = 1'b1;
                        flush_ex = 1'b1;
                    end else if (mc_start) begin
                        stall_fe  = 1'b0;
                        stall_de  = 1'b0;
                        stall_ex  = 1'b0;
                        bubble_me = 1'b1;
                        cnt_d     = 8'(MC_CYCLES - 2);
                        state_d   = MCWAIT;
                    end else if (ld_hazard) begin
                        stall_fe = 1'b0;
                        stall_de = 1'b0;
                        flush_ex = 1'b1;
                        state_d  = LDSTALL;
                    end
                end
                // EXE already holds the bubble; re-seen hazard must not stall again.
                LDSTALL: state_d = RUN;
                MCWAIT: begin
                    if (cnt_q != 8'd0) begin
                        stall_fe  = 1'b0;
                        stall_de  = 1'b0;
                        stall_ex  = 1'b0;
                        bubble_me = 1'b1;
                        cnt_d     = cnt_q - 8'd1;
                    end else begin
                        mc_done = 1'b1;
                        state_d = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (cnt_clr)
            stall_cycles_d = '0;
        else if (!stall_fe && !(&stall_cycles_q))
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end

    assign stall_cycles = stall_cycles_q;

endmodule

// File: doc/pipe_seq_ctrl.md
Name: pipe_seq_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage RISC core.
- Merges four stall/flush causes into per-stage hold and flush controls:
  - load-use request from the hazard unit;
  - taken branch resolved in EXE;
  - multi-cycle EXE op (mul/div);
  - data-memory wait.
- Owns the stall state machine and a stall-cycle performance counter.
- Sits beside the hazard unit; drives the PC/IR, DEC, EXE and MEM pipeline registers.

Parameters:
- MC_CYCLES, 4, total EXE occupancy of a multi-cycle op in cycles; legal range 2..255.
- CNT_W, 16, width of the stall-cycle performance counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- ld_hazard  in  1  load-use RAW request (combinational, from hazard unit).
- br_taken  in  1  branch in EXE resolved taken.
- mc_start  in  1  multi-cycle op present in EXE, first cycle.
- mem_ready  in  1  data memory completes access this cycle.
- cnt_clr  in  1  synchronous clear of stall_cycles.
- stall_fe  out  1  active-low hold of PC and IR.
- stall_de  out  1  active-low hold of DEC register.
- stall_ex  out  1  active-low hold of EXE register.
- stall_me  out  1  active-low hold of MEM register.
- flush_de  out  1  active-high: DEC register loads NOP.
- flush_ex  out  1  active-high: EXE register loads NOP.
- bubble_me  out  1  active-high: MEM register loads NOP.
- mc_done  out  1  one-cycle pulse, multi-cycle op releases EXE.
- stall_cycles  out  CNT_W  count of cycles with stall_fe==0, saturating.

Behaviour:
- Active-low convention: stall_* = 0 means hold; flushes are active-high.
- Outputs are Mealy, combinational from state, cnt and inputs.
- State encoding: RUN, LDSTALL, MCWAIT; 8-bit down-counter cnt.
- Reset (rst=0, asynchronous):
  - state=RUN, cnt=0, stall_cycles=0.
  - While rst=0, outputs are forced: all stall_*=1, all flush/bubble=0, mc_done=0.
- Default outputs: all stall_*=1, flush_de=flush_ex=bubble_me=0, mc_done=0.
- Memory-wait override (mem_ready=0, any state):
  - all four stall_*=0, no flush/bubble, mc_done=0;
  - state and cnt hold.
  - This overrides every rule below.
- RUN, priority br_taken > mc_start > ld_hazard:
  - br_taken: flush_de=1, flush_ex=1, no stall; ld_hazard and mc_start ignored; next RUN.
  - mc_start: stall_fe=stall_de=stall_ex=0, bubble_me=1; cnt<=MC_CYCLES-2; next MCWAIT.
    - If MC_CYCLES==2: next MCWAIT with cnt=0, i.e. release on the following cycle.
  - ld_hazard: stall_fe=stall_de=0, flush_ex=1; next LDSTALL.
  - otherwise: defaults; next RUN.
- LDSTALL:
  - defaults, no stall; all of ld_hazard, br_taken and mc_start are ignored (EXE holds a bubble); next RUN.
  - Guarantees exactly one stall cycle per load-use pair; the re-evaluated hazard never double-stalls.
- MCWAIT:
  - cnt!=0: stall_fe=stall_de=stall_ex=0, bubble_me=1, cnt<=cnt-1; stay.
  - cnt==0: defaults, mc_done=1; next RUN.
  - br_taken, mc_start and ld_hazard are ignored in MCWAIT.
- Stall latencies:
  - multi-cycle op: front end held for exactly MC_CYCLES-1 cycles (excluding memory-wait cycles);
  - load-use: exactly 1 cycle.
- Performance counter, stall_cycles:
  - cnt_clr=1: next value 0; cnt_clr takes priority over increment.
  - Otherwise increments when stall_fe==0.
  - Saturates at all-ones; no wrap.
- Reset mid-operation: asynchronous return to RUN with cnt=0; a pending mc op or load stall is abandoned.

Test Plan:
- Reset: rst=0 with ld_hazard=1 and mem_ready=0 -> all stall_*=1, flushes=0, stall_cycles=0; after release, state RUN.
- Load-use: ld_hazard=1 held for 2 cycles -> cycle 0: stall_fe=stall_de=0, flush_ex=1; cycle 1: no stall; stall_cycles=1.
- Multi-cycle op, MC_CYCLES=4, mc_start=1 one cycle -> stall_fe/de/ex=0 and bubble_me=1 for cycles 0-2; cycle 3: mc_done=1, no stall; stall_cycles=3.
- Priority: br_taken=1 with ld_hazard=1 and mc_start=1 in RUN -> flush_de=flush_ex=1, no stall, next RUN.
- Memory wait inside MCWAIT: mem_ready=0 for 2 cycles mid-op -> all stall_*=0, cnt frozen; total mc_done delay grows by exactly 2 cycles; stall_cycles +2.
- Counter: force 2^CNT_W+3 stall cycles -> stall_cycles saturates at all-ones; cnt_clr=1 during a stall -> 0 on next edge.
